// File: rtl/cond_pkg.sv
// Shared types and constants for the Execute-stage condition unit.
// Flag bit positions within {N,Z,C,V} and flag-write group selects.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition decode against a {N,Z,C,V} flag set.
// Shared with the Decode-stage branch predictor.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condex = 1'b1;
        unique case (cond_e'(cond))
            EQ: condex = z;
            NE: condex = ~z;
            CS: condex = c;
            CC: condex = ~c;
            MI: condex = n;
            PL: condex = ~n;
            VS: condex = v;
            VC: condex = ~v;
            HI: condex = c & ~z;
            LS: condex = ~c | z;
            GE: condex = (n == v);
            LT: condex = (n != v);
            GT: condex = ~z & (n == v);
            LE: condex = z | (n != v);
            AL: condex = 1'b1;
            NV: condex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage NZCV flags register, condition gating of side effects,
// and a saturating count of condition-squashed instructions.
module cond_unit
    import cond_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagWriteE,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             CntClr,
    output logic             CondExE,
    output logic             PCSrcGE,
    output logic             BranchTakenE,
    output logic             RegWriteGE,
    output logic             MemWriteGE,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCnt
);

    logic pass;
    logic upd;
    logic squash;

    cond_check u_check (
        .cond   (CondE),
        .flags  (Flags),
        .condex (CondExE)
    );

    assign pass   = CondExE & ValidE;
    assign upd    = pass & ~StallE;
    assign squash = ValidE & ~StallE & ~CondExE;

    assign PCSrcGE      = PCSrcE & pass;
    assign BranchTakenE = BranchE & pass;
    assign RegWriteGE   = RegWriteE & pass;
    assign MemWriteGE   = MemWriteE & pass;

    // Each flag group is written independently; the other group holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= FLAGS_RST;
        end else if (upd) begin
            if (FlagWriteE[FLAGW_NZ]) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagWriteE[FLAGW_CV]) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            SquashCnt <= '0;
        end else if (CntClr) begin
            SquashCnt <= '0;
        end else if (squash && (SquashCnt != {CNT_W{1'b1}})) begin
            SquashCnt <= SquashCnt + 1'b1;
        end
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the ALU flag interface in the Execute stage of the 5-stage pipeline.
- Holds the architectural NZCV flags register and updates it from the ALU's {N,Z,C,V} flags under per-group write enables.
- Evaluates each Execute-stage instruction's 4-bit condition field against the committed flags, and gates PCSrc/RegWrite/MemWrite/FlagWrite accordingly.
- Also keeps a saturating count of instructions squashed by a failed condition, for perf/debug.

Parameters:
- CNT_W, 16, width of the squash counter.
- FLAGS_RST, 4'b0000, reset value of the flags register {N,Z,C,V}.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- CondE  input  4  ARM condition field of the Execute-stage instruction.
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the Execute-stage instruction.
- FlagWriteE  input  2  [1] = write N,Z; [0] = write C,V.
- PCSrcE  input  1  ungated PC-source request.
- RegWriteE  input  1  ungated register write.
- MemWriteE  input  1  ungated memory write.
- BranchE  input  1  instruction is a branch.
- ValidE  input  1  0 = bubble in Execute.
- StallE  input  1  Execute stage held this cycle.
- CntClr  input  1  synchronous clear of the squash counter.
- CondExE  output  1  condition passed (combinational).
- PCSrcGE  output  1  PCSrcE & CondExE & ValidE.
- BranchTakenE  output  1  BranchE & CondExE & ValidE.
- RegWriteGE  output  1  RegWriteE & CondExE & ValidE.
- MemWriteGE  output  1  MemWriteE & CondExE & ValidE.
- Flags  output  4  registered flags {N,Z,C,V}.
- SquashCnt  output  CNT_W  count of squashed instructions.

Behaviour:
- Reset (reset_n=0, asynchronous): Flags=FLAGS_RST, SquashCnt=0. Gated outputs follow the combinational equations and are 0 whenever ValidE=0.
- Condition decode uses the registered Flags, never ALUFlags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as 1 (unconditional)
- Flag update at the rising edge, when ValidE & ~StallE & CondExE:
  - FlagWriteE[1]: Flags[3:2] <= ALUFlags[3:2].
  - FlagWriteE[0]: Flags[1:0] <= ALUFlags[1:0].
  - Groups are independent; an unwritten group holds its value.
- Latency: a flag write is visible to the condition of the next instruction entering Execute, with zero bubbles. The same instruction evaluates against the old flags.
- Stall: StallE=1 freezes Flags and SquashCnt. Combinational outputs still reflect the held instruction, so the gated outputs stay stable across the stall.
- Bubble: ValidE=0 means no flag write, no count, and all gated outputs 0. CondExE still shows the raw decode.
- Squash counter:
  - Increments on ValidE & ~StallE & ~CondExE.
  - Saturates at all-ones: no wrap.
  - CntClr has priority over increment. Clear and squash in the same cycle gives 0.
- Reset mid-operation: flags return to FLAGS_RST immediately, without waiting for a clock edge.
- No X-propagation: all 16 condition codes are decoded, with no default-X branch.

Decomposition:
- Package cond_pkg:
  - cond_e enum (EQ..AL, NV) of 4 bits.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FLAGW_NZ=1, FLAGW_CV=0.
- One combinational sub-module cond_check (Cond, Flags -> CondEx) holds the decode table and can be reused by the Decode-stage branch predictor.
- The flags register, gating logic and counter live in cond_unit.

Test Plan:
- Reset with FLAGS_RST=0: assert reset_n=0 mid-cycle -> Flags=0 and SquashCnt=0 without a clock. Then CondE=0000 (EQ) -> CondExE=0; CondE=0001 (NE) -> CondExE=1.
- Back-to-back dependency: cycle 1 SUBS, ALUFlags=0100, FlagWriteE=11, CondE=1110. Cycle 2 CondE=0000 with RegWriteE=1 -> Flags=0100 after edge 1, and in cycle 2 CondExE=1 and RegWriteGE=1.
- Partial write: Flags=1111, then ALUFlags=0000 with FlagWriteE=10 -> Flags=0011. Then FlagWriteE=01 with ALUFlags=0000 -> Flags=0000.
- Failed condition suppresses everything: Flags=0000, CondE=0000, RegWriteE=MemWriteE=PCSrcE=BranchE=1, FlagWriteE=11, ALUFlags=1111 -> all gated outputs 0, Flags stay 0000, SquashCnt +1.
- Stall and bubble: StallE=1 with a failing condition for 3 cycles -> SquashCnt unchanged and Flags unchanged. ValidE=0 with FlagWriteE=11 -> no flag write, all gated outputs 0.
- Counter saturation: CNT_W=4, 20 consecutive squashes -> SquashCnt=15 and holds. CntClr asserted together with a squash -> SquashCnt=0.
- Sweep all 16 CondE × 16 flag values -> CondExE matches the reference table; 1111 always gives 1.
